// File: rtl/add_sub_pkg.sv
// Shared types for the add/sub block accumulator.
// Widths, sample/accumulator types and FSM states.
package add_sub_pkg;

  localparam int N     = 32;
  localparam int ACC_W = 40;

  typedef logic signed [N-1:0]     sample_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } acc_state_t;

endpackage

// File: rtl/sat_adder.sv
// Saturating add of a sign-extended sample into an accumulator.
// Ports: i_acc, i_smp in; o_sum clamped sum, o_ovf clamp flag out.
module sat_adder #(
  parameter int N     = add_sub_pkg::N,
  parameter int ACC_W = add_sub_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [N-1:0]     i_smp,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  logic signed [ACC_W:0] w_wide;
  logic [ACC_W-1:0]      w_max;
  logic [ACC_W-1:0]      w_min;

  assign w_wide = {i_acc[ACC_W-1], i_acc}
                + {{(ACC_W+1-N){i_smp[N-1]}}, i_smp};

  assign w_max = {1'b0, {(ACC_W-1){1'b1}}};
  assign w_min = {1'b1, {(ACC_W-1){1'b0}}};

  // Top two bits disagree only when the sum left the ACC_W range.
  assign o_ovf = w_wide[ACC_W] ^ w_wide[ACC_W-1];

  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    if (o_ovf) o_sum = w_wide[ACC_W] ? w_min : w_max;
  end

endmodule

// File: rtl/add_sub_block_accumulator.sv
// Integrates BLOCK_LEN signed samples into one saturated block sum.
// Ports: clk, reset_n, clear, in_* stream in, out_* block out, busy.
module add_sub_block_accumulator #(
  parameter int N         = add_sub_pkg::N,
  parameter int ACC_W     = add_sub_pkg::ACC_W,
  parameter int BLOCK_LEN = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_ovf,
  output logic                    busy
);

  import add_sub_pkg::*;

  localparam int CW = $clog2(BLOCK_LEN + 1);

  if (BLOCK_LEN < 2 || BLOCK_LEN > 256 || ACC_W <= N) begin : g_bad
    $error("add_sub_block_accumulator: illegal BLOCK_LEN or ACC_W");
  end

  acc_state_t              r_state, w_state;
  logic signed [ACC_W-1:0] r_acc, w_acc;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic                    r_ovf, w_ovf;
  logic                    r_ov, w_ov;
  logic signed [ACC_W-1:0] r_od, w_od;
  logic                    r_oo, w_oo;

  logic signed [ACC_W-1:0] w_sum;
  logic                    w_sat;
  logic                    w_acc_en;
  logic                    w_last;

  sat_adder #(
    .N     (N),
    .ACC_W (ACC_W)
  ) u_sat (
    .i_acc (r_acc),
    .i_smp (in_data),
    .o_sum (w_sum),
    .o_ovf (w_sat)
  );

  assign in_ready  = (r_state != HOLD);
  assign w_acc_en  = in_valid && in_ready;
  assign w_last    = (r_cnt == CW'(BLOCK_LEN - 1));
  assign out_valid = r_ov;
  assign out_data  = r_od;
  assign out_ovf   = r_oo;
  assign busy      = (r_cnt != '0);

  always_comb begin
    w_state = r_state;
    w_acc   = r_acc;
    w_cnt   = r_cnt;
    w_ovf   = r_ovf;
    w_ov    = r_ov;
    w_od    = r_od;
    w_oo    = r_oo;
    if (clear) begin
      w_state = IDLE;
      w_acc   = '0;
      w_cnt   = '0;
      w_ovf   = 1'b0;
      w_ov    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc_en) begin
            w_acc   = {{(ACC_W-N){in_data[N-1]}}, in_data};
            w_cnt   = CW'(1);
            w_state = ACCUM;
          end
        end
        ACCUM: begin
          if (w_acc_en) begin
            if (w_last) begin
              w_od    = w_sum;
              w_oo    = r_ovf | w_sat;
              w_ov    = 1'b1;
              w_acc   = '0;
              w_cnt   = '0;
              w_ovf   = 1'b0;
              w_state = HOLD;
            end else begin
              w_acc = w_sum;
              w_cnt = r_cnt + CW'(1);
              w_ovf = r_ovf | w_sat;
            end
          end
        end
        HOLD: begin
          if (r_ov && out_ready) begin
            w_ov    = 1'b0;
            w_state = IDLE;
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_ov    <= 1'b0;
      r_od    <= '0;
      r_oo    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt;
      r_ovf   <= w_ovf;
      r_ov    <= w_ov;
      r_od    <= w_od;
      r_oo    <= w_oo;
    end
  end

endmodule

// File: tb/tb_add_sub_block_accumulator.sv
// Scoreboard bench for add_sub_block_accumulator (ACC_W=33).
// Directed blocks plus a randomized stream against a model.
module tb_add_sub_block_accumulator;

  localparam int N     = 32;
  localparam int ACC_W = 33;
  localparam int BL    = 8;
  localparam longint SMAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (ACC_W-1));

  typedef struct {
    longint d;
    bit     o;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_ovf;
  logic                    busy;

  int     n_vec = 0;
  int     n_mis = 0;
  exp_t   q[$];
  bit     auto_exp = 1'b0;
  int     or_mode = 1;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;

  add_sub_block_accumulator #(
    .N         (N),
    .ACC_W     (ACC_W),
    .BLOCK_LEN (BL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input longint d, input bit o);
    exp_t e;
    e.d = d;
    e.o = o;
    q.push_back(e);
  endtask

  task automatic model(input logic signed [N-1:0] d);
    longint s;
    bit     sat;
    s = longint'(d);
    sat = 1'b0;
    if (m_cnt != 0) begin
      s = m_acc + s;
      if (s > SMAX) begin s = SMAX; sat = 1'b1; end
      if (s < SMIN) begin s = SMIN; sat = 1'b1; end
    end
    m_acc = s;
    m_ovf = m_ovf | sat;
    m_cnt++;
    if (m_cnt == BL) begin
      push(m_acc, m_ovf);
      m_acc = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic send(input logic signed [N-1:0] d);
    int n;
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready && !clear) begin
        done = 1'b1;
        if (auto_exp) model(d);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      n_vec++;
      n_mis++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_mis++;
          $display("FAIL sb_unexpected: got %0d expected none",
                   longint'(out_data));
        end else begin
          e = q.pop_front();
          chk("sb_data", longint'(out_data), e.d);
          chk("sb_ovf", longint'(out_ovf), longint'(e.o));
        end
      end
    end
  endtask

  task automatic ready_drv();
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    fork
      monitor();
      ready_drv();
    join_none

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset mid-block
    repeat (3) send(1);
    chk("pre_rst_busy", longint'(busy), 1);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    @(posedge clk);
    #1;
    push(8, 0);
    repeat (BL) send(1);

    // basic block 10..17 = 108
    push(108, 0);
    for (int i = 10; i < 18; i++) send(i);
    @(negedge clk);
    chk("basic_ov_rise", longint'(out_valid), 1);
    chk("basic_rdy_low", longint'(in_ready), 0);
    @(negedge clk);
    chk("basic_ov_fall", longint'(out_valid), 0);
    chk("basic_rdy_back", longint'(in_ready), 1);
    @(posedge clk);
    #1;

    // signed block with backpressure
    or_mode = 0;
    push(-40, 0);
    repeat (BL) send(-5);
    in_valid = 1'b1;
    in_data  = 3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_rdy", longint'(in_ready), 0);
      chk("bp_data", longint'(out_data), -40);
      @(posedge clk);
      #1;
    end
    or_mode = 1;
    @(posedge clk);
    #1;
    chk("bp_no_accept_hs", longint'(busy), 0);
    @(negedge clk);
    chk("bp_rdy_after_hs", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_next", longint'(busy), 1);
    push(3, 0);
    repeat (BL - 1) send(0);

    // saturation
    push(SMAX, 1);
    repeat (BL) send(32'sh7FFFFFFF);
    push(0, 0);
    repeat (BL) send(0);

    // clear with colliding sample
    repeat (5) send(100);
    in_valid = 1'b1;
    in_data  = 7;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_busy", longint'(busy), 0);
    chk("clr_rdy", longint'(in_ready), 1);
    push(8, 0);
    repeat (BL) send(1);

    // random stream against model
    auto_exp = 1'b1;
    or_mode  = 2;
    for (int k = 0; k < 200; k++) begin
      int sel;
      logic signed [N-1:0] v;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = 32'sh7FFFFFFF;
        1:       v = 32'sh80000000;
        default: v = $urandom;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(v);
    end
    or_mode = 1;
    for (int w = 0; w < 20 && q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    chk("sb_drained", longint'(q.size()), 0);
    chk("model_cnt", longint'(m_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_mis);
    $finish;
  end

endmodule
